// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

  localparam int          INSTR_WIDTH        = 32;
  localparam int          DEFAULT_ADDR_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0;

  function automatic logic word_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch bus: instruction-memory request/response plus the decode-side output port.
interface fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  import fetch_pkg::*;

  logic                   imem_req_valid;
  logic [ADDR_WIDTH-1:0]  imem_req_addr;
  logic                   imem_req_ready;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   out_valid;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic                   out_ready;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO with flush; push and pop may coincide even when full.
module fetch_buf #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    full, do_push, do_pop;

  assign full    = count == (PW+1)'(DEPTH);
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // storage is reset too so the head reads zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues word requests, buffers
// returned words for decode and handles redirect/trap with stale-response draining.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  trap_valid,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  output logic                  misaligned,
  fetch_if.master               bus
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n, tgt, rsp_pc;
  cnt_t                  inflight, count, stale_cnt, stale_n;
  logic                  hs, rsp_live, take_trap, take_redir, flush;
  entry_t                head, rsp_entry;

  assign hs         = bus.imem_req_valid && bus.imem_req_ready;
  assign take_trap  = trap_valid;
  assign take_redir = redirect_valid && !trap_valid && (state != HALT);
  assign flush      = take_trap || take_redir;
  assign tgt        = take_trap ? trap_pc : redirect_pc;
  assign rsp_live   = bus.imem_rsp_valid && (stale_cnt == '0) && !flush;

  // cap counts words in flight plus words parked, so the buffer can never overflow
  assign bus.imem_req_valid = (state == RUN) &&
    (({1'b0, inflight} + {1'b0, count}) < (CW+1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = {fetch_pc[ADDR_WIDTH-1:2], 2'b00};

  assign bus.out_valid = count != '0;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign rsp_entry     = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    stale_n    = stale_cnt;
    if (hs) fetch_pc_n = fetch_pc + ADDR_WIDTH'(4);
    if (bus.imem_rsp_valid && (stale_cnt != '0)) stale_n = stale_cnt - cnt_t'(1);
    case (state)
      IDLE:    state_n = RUN;
      FLUSH:   if (stale_cnt == '0) state_n = RUN;
      default: ;
    endcase
    // everything still owed by memory becomes stale; a same-cycle response is dropped
    if (flush) begin
      fetch_pc_n = tgt;
      stale_n    = stale_cnt + inflight + cnt_t'(hs) - cnt_t'(bus.imem_rsp_valid);
      state_n    = (stale_n != '0) ? FLUSH : RUN;
      if (take_redir && !word_aligned(redirect_pc[1:0])) state_n = HALT;
      if (take_trap && (state == HALT) && !word_aligned(trap_pc[1:0])) state_n = HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      stale_cnt  <= '0;
      misaligned <= 1'b0;
    end else begin
      fetch_pc   <= fetch_pc_n;
      stale_cnt  <= stale_n;
      misaligned <= state_n == HALT;
    end
  end

  // request-PC side queue; its occupancy is the current-epoch in-flight count
  fetch_buf #(.W(ADDR_WIDTH), .DEPTH(BUF_DEPTH)) u_pcq (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (hs),
    .push_data (bus.imem_req_addr),
    .pop       (rsp_live),
    .head      (rsp_pc),
    .count     (inflight)
  );

  fetch_buf #(.W($bits(entry_t)), .DEPTH(BUF_DEPTH)) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (rsp_live),
    .push_data (rsp_entry),
    .pop       (bus.out_ready),
    .head      (head),
    .count     (count)
  );

endmodule
